// File: rtl/mem_wb_stage_if.sv
// MEM/WB channel interface: one valid/ready handshake plus the write-back payload.
// The stage takes the slave view on its upstream side and the master view downstream.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              valid;
  logic              ready;
  logic              regWrite;
  logic              memToReg;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] addr;
  logic [RD_W-1:0]   rd;

  modport master (
    output valid, regWrite, memToReg, rdata, addr, rd,
    input  ready
  );

  modport slave (
    input  valid, regWrite, memToReg, rdata, addr, rd,
    output ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a 2-entry skid buffer (head + skid register).
// in_ready depends only on registered state, so there is no combinational
// path from the write-back side back to the MEM stage.
// Optional feature: define MEM_WB_PERF_EN to add the saturating stall_cnt port.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  mem_wb_stage_if.slave     inBus,
  mem_wb_stage_if.master    outBus,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int PAY_W = 2 + 2 * DATA_W + RD_W;

  // State encoding is {headValid, skidValid}.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  logic [1:0]       state;
  logic [PAY_W-1:0] headPay;
  logic [PAY_W-1:0] skidPay;
  logic [PAY_W-1:0] inPay;
  logic             hV;
  logic             sV;
  logic             accept;
  logic             drain;

  assign hV     = state[1];
  assign sV     = state[0];
  assign inPay  = {inBus.regWrite, inBus.memToReg, inBus.rdata, inBus.addr, inBus.rd};

  assign inBus.ready  = !sV;
  assign accept       = inBus.valid && !sV;
  assign drain        = hV && outBus.ready;

  assign outBus.valid = hV;
  assign {outBus.regWrite, outBus.memToReg, outBus.rdata, outBus.addr, outBus.rd} = headPay;

  assign wb_data      = outBus.memToReg ? outBus.rdata : outBus.addr;
  assign wb_reg_write = hV && outBus.regWrite && (outBus.rd != '0);

  // Buffer control: reset beats flush beats normal traffic; the skid entry
  // is promoted to head whenever the head drains while FULL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      headPay <= '0;
      skidPay <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            headPay <= inPay;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            headPay <= inPay;
          end else if (accept) begin
            skidPay <= inPay;
            state   <= FULL;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            headPay <= skidPay;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef MEM_WB_PERF_EN
  // Count cycles where WB holds off a valid head; saturate, and survive flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hV && !outBus.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unusedCntW;
  assign unusedCntW = (CNT_W > 0);
`endif

endmodule
